// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the sync_fifo family of adapters.
//   DEFAULT_DATA_WIDTH : default word width, matches sync_fifo
//   DEFAULT_BUF_DEPTH  : default prefetch depth (smallest depth for full rate)
//   FIFO_RD_LATENCY    : cycles from an accepted r_en to valid data_out
//   RD_COUNT_W         : width of the delivered-word counter
//   buf_op_e           : per-cycle operation applied to a circular buffer
//   count_width()      : bits needed to hold an occupancy of 0..depth
// -----------------------------------------------------------------------------
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_BUF_DEPTH  = 3;
  localparam int FIFO_RD_LATENCY    = 1;
  localparam int RD_COUNT_W         = 16;

  typedef enum logic [1:0] {
    BUF_IDLE = 2'b00,
    BUF_PUSH = 2'b01,
    BUF_POP  = 2'b10,
    BUF_BOTH = 2'b11
  } buf_op_e;

  // Occupancy runs 0..depth inclusive, hence depth+1 distinct values.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_buf.sv
// -----------------------------------------------------------------------------
// stream_buf
// Small circular buffer with push/pop and an occupancy count. Storage is a
// register array (reset to zero) so the head word is a registered value.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail this edge
//   push_data   : word to write
//   pop         : consume the head word this edge (ignored when empty)
//   pop_data    : current head word
//   count       : occupancy, 0..DEPTH
//   empty       : count == 0
// The caller guarantees no push into a full buffer unless it also pops.
// -----------------------------------------------------------------------------
module stream_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_BUF_DEPTH,
  parameter int CNT_W      = count_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0]      count,
  output logic                  empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg;
  logic [PTR_W-1:0]      rd_ptr_reg;
  logic [CNT_W-1:0]      count_reg;
  logic [CNT_W-1:0]      count_next;
  logic                  pop_fire;
  buf_op_e               op;

  // Explicit wrap so non-power-of-two depths cycle through 0..DEPTH-1 only.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_reg == '0);
  assign pop_fire = pop & ~empty;
  assign count    = count_reg;
  assign pop_data = mem_reg[rd_ptr_reg];

  always_comb begin
    op = BUF_IDLE;
    if (push && pop_fire) begin
      op = BUF_BOTH;
    end else if (push) begin
      op = BUF_PUSH;
    end else if (pop_fire) begin
      op = BUF_POP;
    end
  end

  // Simultaneous push and pop leaves the occupancy unchanged.
  always_comb begin
    count_next = count_reg;
    case (op)
      BUF_PUSH: count_next = count_reg + CNT_W'(1);
      BUF_POP:  count_next = count_reg - CNT_W'(1);
      default:  count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      count_reg <= count_next;
      if (push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (pop_fire) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
    end
  end

  // Storage is cleared on reset so the head word reads zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
// Drains a sync_fifo through its r_en/data_out/empty port and presents the
// words on a valid/ready stream. A small prefetch buffer hides the FIFO's
// one-cycle read latency so the stream can sustain one word per cycle.
// Ports:
//   clk, rst_n     : clock shared with sync_fifo, asynchronous active-low reset
//   fifo_r_en      : read strobe to sync_fifo.r_en
//   fifo_data_out  : sync_fifo.data_out, valid the cycle after an accepted read
//   fifo_empty     : sync_fifo.empty
//   m_valid        : a stream word is available
//   m_ready        : consumer accepts the word
//   m_data         : stream word (buffer head)
//   rd_count       : words delivered since reset, wraps at 2^16
// -----------------------------------------------------------------------------
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BUF_DEPTH  = DEFAULT_BUF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [RD_COUNT_W-1:0] rd_count
);

  localparam int CNT_W = count_width(BUF_DEPTH);
  localparam int SUM_W = CNT_W + 1;

  generate
    if (BUF_DEPTH < 2) begin : g_bad_depth
      $error("fifo_stream_reader: BUF_DEPTH must be at least 2");
    end
  endgenerate

  logic [CNT_W-1:0]      buf_count;
  logic                  buf_empty;
  logic [DATA_WIDTH-1:0] buf_head;
  logic                  in_flight_reg;
  logic [RD_COUNT_W-1:0] rd_count_reg;
  logic [SUM_W-1:0]      committed;
  logic                  credit_ok;
  logic                  handshake;

  // Credit: every word already buffered or still on its way from the FIFO
  // holds a slot, so a read is only issued when a slot is guaranteed free at
  // the edge the data lands. The pop side is deliberately left out so that
  // m_ready never reaches fifo_r_en combinationally.
  assign committed = {1'b0, buf_count} + SUM_W'(in_flight_reg);
  assign credit_ok = (committed < SUM_W'(BUF_DEPTH));

  // rst_n is included so the strobe drops the instant reset asserts.
  assign fifo_r_en = rst_n & ~fifo_empty & credit_ok;

  assign m_valid   = ~buf_empty;
  assign m_data    = buf_head;
  assign handshake = m_valid & m_ready;
  assign rd_count  = rd_count_reg;

  // in_flight marks that data_out carries a fresh word this cycle
  // (FIFO_RD_LATENCY cycles after the accepted read).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_flight_reg <= 1'b0;
      rd_count_reg  <= '0;
    end else begin
      in_flight_reg <= fifo_r_en;
      if (handshake) begin
        rd_count_reg <= rd_count_reg + RD_COUNT_W'(1);
      end
    end
  end

  stream_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (BUF_DEPTH),
    .CNT_W      (CNT_W)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_flight_reg),
    .push_data (fifo_data_out),
    .pop       (m_ready),
    .pop_data  (buf_head),
    .count     (buf_count),
    .empty     (buf_empty)
  );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_stream_reader
// The bench plays the sync_fifo (a queue with one-cycle read latency) and
// tracks expected stream behaviour with queues: words read from the FIFO land
// in the buffer one edge later; the head of the buffer queue is the expected
// stream word; a scoreboard holds the overall write order.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

  localparam int DW    = 8;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_r_en;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [15:0]   rd_count;

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_r_en     (fifo_r_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .rd_count      (rd_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int cyc      = 0;
  int hs_count = 0;
  int hs_cyc   = -1;
  logic [DW-1:0] hs_data;

  logic [DW-1:0] fq[$];   // FIFO contents
  logic [DW-1:0] bq[$];   // words expected in the prefetch buffer
  logic [DW-1:0] sb[$];   // write order scoreboard
  logic          pend_v = 1'b0;
  logic [DW-1:0] pend_d = '0;
  logic [15:0]   rdc    = '0;

  logic [DW-1:0] smp_data;
  logic          smp_ren;
  int            smp_occ;

  logic [DW-1:0] words [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    assert (obs === want)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic fifo_push(input logic [DW-1:0] w);
    fq.push_back(w);
    sb.push_back(w);
    fifo_empty = 1'b0;
  endtask

  // One clock cycle: check at the falling edge, then advance the models
  // just after the rising edge.
  task automatic cycle();
    logic rd;
    logic hs;
    @(negedge clk);
    smp_data = m_data;
    smp_ren  = fifo_r_en;
    smp_occ  = bq.size() + int'(pend_v);
    chk("occupancy_le_depth", 32'(smp_occ <= DEPTH), 1);
    chk("m_valid", m_valid, bq.size() != 0);
    if (bq.size() != 0) chk("m_data", m_data, bq[0]);
    chk("fifo_r_en", fifo_r_en, (fq.size() != 0) && (smp_occ < DEPTH));
    chk("rd_count", rd_count, rdc);
    hs = (bq.size() != 0) && m_ready;
    rd = fifo_r_en && (fq.size() != 0);
    if (hs) begin
      chk("stream_order", m_data, sb[0]);
      hs_data = m_data;
      void'(sb.pop_front());
      void'(bq.pop_front());
      rdc = rdc + 16'd1;
      hs_count++;
      hs_cyc = cyc;
    end
    @(posedge clk);
    #1;
    if (pend_v) bq.push_back(pend_d);
    pend_v = 1'b0;
    if (rd) begin
      pend_d        = fq.pop_front();
      pend_v        = 1'b1;
      fifo_data_out = pend_d;
    end
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  initial begin
    int base;
    int n0;
    int first;
    int stall_left;
    bit stall_armed;
    bit saw_full;
    logic [DW-1:0] stall_data;
    logic [15:0] wrap_exp [3];
    int k;

    rst_n         = 1'b0;
    m_ready       = 1'b0;
    fifo_empty    = 1'b1;
    fifo_data_out = '0;

    // Reset hold
    @(negedge clk);
    chk("rst_fifo_r_en", fifo_r_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rd_count", rd_count, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    $display("step: idle after reset, checks=%0d errors=%0d", n_checks, n_errors);

    // Single word latency
    m_ready = 1'b1;
    n0      = cyc;
    base    = hs_count;
    fifo_push(8'hA5);
    for (int t = 0; t < 10 && hs_count == base; t++) cycle();
    chk("a5_handshakes", hs_count - base, 1);
    chk("a5_latency", hs_cyc - n0, 2);
    chk("a5_data", hs_data, 8'hA5);
    chk("a5_rd_count", rd_count, 1);
    $display("step: single word 0xa5, latency=%0d", hs_cyc - n0);

    // Full-rate burst
    for (int i = 0; i < 16; i++) words[i] = DW'($urandom);
    for (int i = 0; i < 16; i++) fifo_push(words[i]);
    base  = hs_count;
    first = -1;
    for (int t = 0; t < 60 && hs_count - base < 16; t++) begin
      cycle();
      if (first < 0 && hs_count - base == 1) first = hs_cyc;
    end
    chk("burst_count", hs_count - base, 16);
    chk("burst_no_bubbles", hs_cyc - first, 15);
    $display("step: burst of 16, span=%0d cycles", hs_cyc - first + 1);

    // Toggling ready with a 10-cycle stall after word 5
    for (int i = 0; i < 16; i++) fifo_push(words[i]);
    base        = hs_count;
    stall_left  = 0;
    stall_armed = 1'b1;
    saw_full    = 1'b0;
    stall_data  = '0;
    m_ready     = 1'b0;
    for (int t = 0; t < 200 && hs_count - base < 16; t++) begin
      if (stall_left > 0) m_ready = 1'b0;
      else m_ready = ~m_ready;
      cycle();
      if (smp_occ == DEPTH && !smp_ren) saw_full = 1'b1;
      if (stall_left > 0) begin
        chk("stall_data_stable", smp_data, stall_data);
        stall_left--;
      end
      if (stall_armed && hs_count - base == 5 && bq.size() != 0) begin
        stall_armed = 1'b0;
        stall_left  = 10;
        stall_data  = bq[0];
      end
    end
    chk("toggle_count", hs_count - base, 16);
    chk("toggle_stall_seen", 32'(stall_armed), 0);
    chk("toggle_credit_stop", 32'(saw_full), 1);
    $display("step: toggled ready with stall, delivered=%0d", hs_count - base);

    // Reset in the middle of a transfer
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) fifo_push(DW'($urandom));
    base = hs_count;
    for (int t = 0; t < 20 && hs_count - base < 2; t++) cycle();
    chk("mid_rst_pre_handshakes", hs_count - base, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fifo_r_en", fifo_r_en, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_rd_count", rd_count, 0);
    fq.delete();
    bq.delete();
    sb.delete();
    pend_v     = 1'b0;
    rdc        = '0;
    fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc++;
    for (int i = 0; i < 10; i++) cycle();
    chk("post_rst_no_stale", hs_count - base, 2);
    $display("step: mid-stream reset, rd_count=%0d", rd_count);

    // rd_count wrap
    force dut.rd_count_reg = 16'hFFFE;
    #1;
    release dut.rd_count_reg;
    rdc = 16'hFFFE;
    wrap_exp[0] = 16'hFFFF;
    wrap_exp[1] = 16'h0000;
    wrap_exp[2] = 16'h0001;
    k = 0;
    for (int i = 0; i < 3; i++) fifo_push(DW'($urandom));
    base = hs_count;
    for (int t = 0; t < 20 && k < 3; t++) begin
      n0 = hs_count;
      cycle();
      if (hs_count != n0) begin
        chk("rd_count_wrap", rd_count, wrap_exp[k]);
        $display("step: wrap handshake %0d, rd_count=%h", k, rd_count);
        k++;
      end
    end
    chk("wrap_handshakes", k, 3);
    for (int i = 0; i < 4; i++) cycle();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
